regfile_write_arbiter: RTL

Arbitrates the single write port of the 8×16 register file between two write-back requesters: ALU write-back (rq0) and load unit (rq1). Keeps a per-register pending-write scoreboard so the issue stage can reserve destinations and stall on read-after-write hazards. Sits between the execute/memory stages and the register file. Optionally forwards same-cycle write data onto the register file's A/B read outputs.

---
 rtl/regfile_write_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Arbitrates the single write port of an 8x16 register file between the
//   ALU write-back requester (rq0) and the load unit (rq1). It also keeps a
//   per-register pending-write scoreboard, so the issue stage can reserve
//   destinations and detect read-after-write hazards on the A/B operands.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   rq0_valid/addr/data/ready   ALU write-back request and grant
//   rq1_valid/addr/data/ready   load-unit write-back request and grant
//   rsv_valid/addr/ready        destination reservation from issue
//   AA, BA                      register file read addresses
//   a_in, b_in                  register file read data
//   a_out, b_out                operand data to the datapath
//   hazard_a, hazard_b          operand has an outstanding write
//   we, DA, data                register file write port
//   pending                     scoreboard, bit i = register i reserved
//
// Optional feature
//   REGFILE_WRITE_FWD_EN: forward same-cycle write data onto a_out/b_out
//   and suppress the matching hazard for that cycle.
module regfile_write_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rq0_valid,
    input  logic [2:0]  rq0_addr,
    input  logic [15:0] rq0_data,
    output logic        rq0_ready,
    input  logic        rq1_valid,
    input  logic [2:0]  rq1_addr,
    input  logic [15:0] rq1_data,
    output logic        rq1_ready,
    input  logic        rsv_valid,
    input  logic [2:0]  rsv_addr,
    output logic        rsv_ready,
    input  logic [2:0]  AA,
    input  logic [2:0]  BA,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic [15:0] a_out,
    output logic [15:0] b_out,
    output logic        hazard_a,
    output logic        hazard_b,
    output logic        we,
    output logic [2:0]  DA,
    output logic [15:0] data,
    output logic [7:0]  pending
);

    // r_prio selects the winner when both requesters are valid (0 = rq0).
    logic       r_prio;
    logic [7:0] r_pending;

    logic       w_gnt0;
    logic       w_gnt1;
    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic       w_fwd_a;
    logic       w_fwd_b;

    // Grants are suppressed during reset so an in-flight request is never
    // accepted in the reset cycle and must be presented again afterwards.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (rq0_valid && rq1_valid) begin
                w_gnt0 = !r_prio;
                w_gnt1 = r_prio;
            end else begin
                w_gnt0 = rq0_valid;
                w_gnt1 = rq1_valid;
            end
        end
    end

    assign rq0_ready = w_gnt0;
    assign rq1_ready = w_gnt1;

    // Write port: idle drives zeros rather than a stale requester's fields.
    always_comb begin
        we   = w_gnt0 | w_gnt1;
        DA   = 3'd0;
        data = 16'h0000;
        if (w_gnt0) begin
            DA   = rq0_addr;
            data = rq0_data;
        end else if (w_gnt1) begin
            DA   = rq1_addr;
            data = rq1_data;
        end
    end

    // A pending register cannot be reserved again, so set and clear never
    // hit the same bit in one cycle.
    assign rsv_ready = !rst && rsv_valid && !r_pending[rsv_addr];
    assign w_set     = rsv_ready ? (8'h01 << rsv_addr) : 8'h00;
    assign w_clr     = we ? (8'h01 << DA) : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio    <= 1'b0;
            r_pending <= 8'h00;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_gnt0) begin
                r_prio <= 1'b1;
            end else if (w_gnt1) begin
                r_prio <= 1'b0;
            end
        end
    end

    assign pending = r_pending;

`ifdef REGFILE_WRITE_FWD_EN
    assign w_fwd_a = we && (DA == AA);
    assign w_fwd_b = we && (DA == BA);
    assign a_out   = w_fwd_a ? data : a_in;
    assign b_out   = w_fwd_b ? data : b_in;
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
    assign a_out   = a_in;
    assign b_out   = b_in;
`endif

    // Hazards are held low during reset; the scoreboard only clears at the
    // reset edge, so this keeps the reset-cycle outputs clean.
    assign hazard_a = !rst && r_pending[AA] && !w_fwd_a;
    assign hazard_b = !rst && r_pending[BA] && !w_fwd_b;

endmodule
